// File: rtl/vedic_div_pkg.sv
// vedic_div_pkg: shared widths, constants and FSM state type for the 8/4 divider
// Contents: DIVIDEND_W, DIVISOR_W, CNT_W, divide-by-zero results, uio_oe value, state_t
package vedic_div_pkg;
    localparam int DIVIDEND_W = 8;
    localparam int DIVISOR_W  = 4;
    localparam int CNT_W      = $clog2(DIVIDEND_W);
    localparam logic [DIVIDEND_W-1:0] Q_DIV0 = 8'hFF;
    localparam logic [DIVISOR_W-1:0]  R_DIV0 = 4'hF;
    localparam logic [7:0]            UIO_OE = 8'b1100_0000;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/div_restore_step.sv
// div_restore_step: one combinational restoring-division step
// Ports: r (partial remainder in), din (next dividend bit), divisor,
//        r_next (partial remainder out), qbit (quotient bit)
module div_restore_step
    import vedic_div_pkg::*;
(
    input  logic [DIVISOR_W:0]   r,
    input  logic                 din,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W:0]   r_next,
    output logic                 qbit
);
    logic [DIVISOR_W:0] r_sh;
    // r is always below divisor, so the shifted value fits in DIVISOR_W+1 bits
    assign r_sh   = {r[DIVISOR_W-1:0], din};
    assign qbit   = r_sh >= {1'b0, divisor};
    assign r_next = qbit ? r_sh - {1'b0, divisor} : r_sh;
endmodule

// File: rtl/tt_um_vedic_div_8x4.sv
// tt_um_vedic_div_8x4: sequential 8-bit by 4-bit restoring divider, one quotient bit per clock
// Ports: clk, rst_n (async active-low), ena (hold when low), ui_in (dividend),
//        uio_in[3:0] divisor, [4] start, [5] result select (0 quotient, 1 remainder),
//        uo_out selected result, uio_out[6] busy, [7] done, uio_oe fixed 8'hC0
module tt_um_vedic_div_8x4
    import vedic_div_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    state_t                state;
    logic                  start_q;
    logic                  busy;
    logic                  done;
    logic [DIVIDEND_W-1:0] sh;
    logic [DIVISOR_W-1:0]  divisor_q;
    logic [DIVISOR_W:0]    r;
    logic [CNT_W-1:0]      cnt;
    logic [DIVIDEND_W-1:0] q_res;
    logic [DIVISOR_W-1:0]  r_res;
    logic [DIVISOR_W:0]    r_next;
    logic                  qbit;
    logic                  start;
    logic                  launch;
    logic                  unused;

    assign start  = uio_in[4];
    assign launch = start & ~start_q & (state != BUSY);
    assign unused = &{1'b0, uio_in[7:6]};

    div_restore_step u_step (
        .r       (r),
        .din     (sh[DIVIDEND_W-1]),
        .divisor (divisor_q),
        .r_next  (r_next),
        .qbit    (qbit)
    );

    // sh shifts dividend bits out at the MSB and quotient bits in at the LSB,
    // so after the last step it holds the full quotient
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            start_q   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sh        <= '0;
            divisor_q <= '0;
            r         <= '0;
            cnt       <= '0;
            q_res     <= '0;
            r_res     <= '0;
        end else if (ena) begin
            start_q <= start;
            if (launch) begin
                state     <= BUSY;
                busy      <= 1'b1;
                done      <= 1'b0;
                sh        <= ui_in;
                divisor_q <= uio_in[DIVISOR_W-1:0];
                r         <= '0;
                cnt       <= '0;
            end else if (state == BUSY && divisor_q == '0) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
                q_res <= Q_DIV0;
                r_res <= R_DIV0;
            end else if (state == BUSY) begin
                sh  <= {sh[DIVIDEND_W-2:0], qbit};
                r   <= r_next;
                cnt <= cnt + 1'b1;
                if (cnt == CNT_W'(DIVIDEND_W - 1)) begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    q_res <= {sh[DIVIDEND_W-2:0], qbit};
                    r_res <= r_next[DIVISOR_W-1:0];
                end
            end
        end
    end

    assign uo_out  = uio_in[5] ? {4'b0, r_res} : q_res;
    assign uio_out = {done, busy, 6'b0};
    assign uio_oe  = UIO_OE;
endmodule
